// File: rtl/join2_buffered_pkg.sv
// Shared types and helpers for the buffered two-input stream join.
// Pointer width carries one extra wrap bit so full and empty can be told apart.
package join2_buffered_pkg;

    localparam int DEFAULT_DEPTH = 2;

    function automatic int clog2_depth(input int depth);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < depth) w = i + 1;
        end
        return w;
    endfunction

    localparam int PTR_W = $clog2(DEFAULT_DEPTH) + 1;

    typedef logic [PTR_W-1:0] ptr_t;

endpackage

// File: rtl/join2_slot_fifo.sv
// Synchronous, non-fall-through FIFO used as one side buffer of the join.
// Head data comes from storage only, so a pushed beat is visible one cycle later.
module join2_slot_fifo
    import join2_buffered_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  empty,
    output logic                  full
);

    localparam int AW = clog2_depth(DEPTH);
    localparam int PW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign head_data = mem[rd_ptr[AW-1:0]];

    // Pointers wrap naturally modulo 2*DEPTH through their extra bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + PW'(1);
            if (pop && !empty) rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/join2_buffered.sv
// Two-input stream join: each side buffers up to DEPTH beats, output fires when both hold one.
// Define JOIN2_BUFFERED_STALL_CNT_EN to add a saturating join-imbalance stall counter.
module join2_buffered
    import join2_buffered_pkg::*;
#(
    parameter int DATA_IN_0_WIDTH = 32,
    parameter int DATA_IN_1_WIDTH = 32,
    parameter int DEPTH           = 2,
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [DATA_IN_0_WIDTH-1:0]                 data_in_0,
    input  logic                                       data_in_0_valid,
    output logic                                       data_in_0_ready,
    input  logic [DATA_IN_1_WIDTH-1:0]                 data_in_1,
    input  logic                                       data_in_1_valid,
    output logic                                       data_in_1_ready,
    output logic [DATA_IN_0_WIDTH+DATA_IN_1_WIDTH-1:0] data_out_0,
    output logic                                       data_out_0_valid,
    input  logic                                       data_out_0_ready
`ifdef JOIN2_BUFFERED_STALL_CNT_EN
    ,
    output logic [STALL_CNT_WIDTH-1:0]                 stall_count
`endif
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STALL_CNT_WIDTH < 1) begin : g_bad_params
        $error("join2_buffered: DEPTH must be a power of two >= 2 and STALL_CNT_WIDTH >= 1");
    end

    logic                       empty_0, full_0, push_0;
    logic                       empty_1, full_1, push_1;
    logic                       fire;
    logic [DATA_IN_0_WIDTH-1:0] head_0;
    logic [DATA_IN_1_WIDTH-1:0] head_1;

    // Ready looks only at buffer state, never at the downstream ready.
    assign data_in_0_ready  = !full_0 && !rst;
    assign data_in_1_ready  = !full_1 && !rst;
    assign data_out_0_valid = !empty_0 && !empty_1 && !rst;
    assign data_out_0       = {head_1, head_0};

    assign push_0 = data_in_0_valid && data_in_0_ready;
    assign push_1 = data_in_1_valid && data_in_1_ready;
    assign fire   = data_out_0_valid && data_out_0_ready;

    join2_slot_fifo #(
        .DATA_WIDTH (DATA_IN_0_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo_0 (
        .clk       (clk),
        .rst       (rst),
        .push      (push_0),
        .push_data (data_in_0),
        .pop       (fire),
        .head_data (head_0),
        .empty     (empty_0),
        .full      (full_0)
    );

    join2_slot_fifo #(
        .DATA_WIDTH (DATA_IN_1_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo_1 (
        .clk       (clk),
        .rst       (rst),
        .push      (push_1),
        .push_data (data_in_1),
        .pop       (fire),
        .head_data (head_1),
        .empty     (empty_1),
        .full      (full_1)
    );

`ifdef JOIN2_BUFFERED_STALL_CNT_EN
    // Counts cycles where exactly one side is waiting on the other.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
        end else if ((empty_0 != empty_1) && (stall_count != '1)) begin
            stall_count <= stall_count + STALL_CNT_WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_join2_buffered.sv
// Randomised and directed bench for join2_buffered against a queue-based join model.
// Stall-counter checks run only when JOIN2_BUFFERED_STALL_CNT_EN is defined.
module tb_join2_buffered;

    localparam int W0    = 32;
    localparam int W1    = 32;
    localparam int DEPTH = 2;
    localparam int SW    = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [W0-1:0]     data_in_0;
    logic              data_in_0_valid;
    logic              data_in_0_ready;
    logic [W1-1:0]     data_in_1;
    logic              data_in_1_valid;
    logic              data_in_1_ready;
    logic [W0+W1-1:0]  data_out_0;
    logic              data_out_0_valid;
    logic              data_out_0_ready;
`ifdef JOIN2_BUFFERED_STALL_CNT_EN
    logic [SW-1:0]     stall_count;
`endif

    int total = 0;
    int bad   = 0;

    logic [W0-1:0] q0[$];
    logic [W1-1:0] q1[$];

    join2_buffered #(
        .DATA_IN_0_WIDTH (W0),
        .DATA_IN_1_WIDTH (W1),
        .DEPTH           (DEPTH),
        .STALL_CNT_WIDTH (SW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .data_in_0        (data_in_0),
        .data_in_0_valid  (data_in_0_valid),
        .data_in_0_ready  (data_in_0_ready),
        .data_in_1        (data_in_1),
        .data_in_1_valid  (data_in_1_valid),
        .data_in_1_ready  (data_in_1_ready),
        .data_out_0       (data_out_0),
        .data_out_0_valid (data_out_0_valid),
        .data_out_0_ready (data_out_0_ready)
`ifdef JOIN2_BUFFERED_STALL_CNT_EN
        ,
        .stall_count      (stall_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_in(input bit v0, input logic [W0-1:0] d0,
                          input bit v1, input logic [W1-1:0] d1, input bit ordy);
        data_in_0_valid  = v0;
        data_in_0        = d0;
        data_in_1_valid  = v1;
        data_in_1        = d1;
        data_out_0_ready = ordy;
    endtask

    // Advance one clock and apply the join rules to the reference queues.
    task automatic tick();
        bit p0, p1, f;
        p0 = data_in_0_valid && (q0.size() < DEPTH);
        p1 = data_in_1_valid && (q1.size() < DEPTH);
        f  = (q0.size() != 0) && (q1.size() != 0) && data_out_0_ready;
        @(posedge clk);
        if (f) begin
            q0.delete(0);
            q1.delete(0);
        end
        if (p0) q0.push_back(data_in_0);
        if (p1) q1.push_back(data_in_1);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        set_in(0, '0, 0, '0, 0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        q0.delete();
        q1.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_in(1, 32'h5, 1, 32'h6, 1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            total++;
            if (data_in_0_ready !== 1'b0) begin bad++; $display("FAIL reset_rdy0 cyc%0d: got %b want 0", i, data_in_0_ready); end
            total++;
            if (data_in_1_ready !== 1'b0) begin bad++; $display("FAIL reset_rdy1 cyc%0d: got %b want 0", i, data_in_1_ready); end
            total++;
            if (data_out_0_valid !== 1'b0) begin bad++; $display("FAIL reset_valid cyc%0d: got %b want 0", i, data_out_0_valid); end
        end
        set_in(0, '0, 0, '0, 1);
        rst = 1'b0;
        q0.delete();
        q1.delete();
        #1;
        total++;
        if (data_in_0_ready !== 1'b1) begin bad++; $display("FAIL release_rdy0: got %b want 1", data_in_0_ready); end
        total++;
        if (data_in_1_ready !== 1'b1) begin bad++; $display("FAIL release_rdy1: got %b want 1", data_in_1_ready); end
        total++;
        if (data_out_0_valid !== 1'b0) begin bad++; $display("FAIL release_valid: got %b want 0", data_out_0_valid); end
    endtask

    task automatic test_balanced();
        logic [W0-1:0]    d0s [3] = '{32'h11, 32'h22, 32'h33};
        logic [W1-1:0]    d1s [3] = '{32'hA1, 32'hA2, 32'hA3};
        logic [W0+W1-1:0] outs [3] = '{64'h000000A1_00000011, 64'h000000A2_00000022,
                                       64'h000000A3_00000033};
        bit exp_v;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            if (i < 3) set_in(1, d0s[i], 1, d1s[i], 1);
            else       set_in(0, '0, 0, '0, 1);
            #1;
            exp_v = (i >= 1) && (i <= 3);
            total++;
            if (data_out_0_valid !== exp_v) begin bad++; $display("FAIL bal_valid cyc%0d: got %b want %b", i, data_out_0_valid, exp_v); end
            if (exp_v) begin
                total++;
                if (data_out_0 !== outs[i-1]) begin bad++; $display("FAIL bal_data cyc%0d: got %h want %h", i, data_out_0, outs[i-1]); end
            end
            total++;
            if ((data_in_0_ready & data_in_1_ready) !== 1'b1) begin bad++; $display("FAIL bal_ready cyc%0d: got %b%b want 11", i, data_in_0_ready, data_in_1_ready); end
            tick();
        end
    endtask

    task automatic test_skew();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(1, W0'(i + 1), 0, '0, 1);
            #1;
            total++;
            if (data_in_0_ready !== (i < 2)) begin bad++; $display("FAIL skew_rdy0 cyc%0d: got %b want %b", i, data_in_0_ready, (i < 2)); end
            total++;
            if (data_out_0_valid !== 1'b0) begin bad++; $display("FAIL skew_valid cyc%0d: got %b want 0", i, data_out_0_valid); end
            tick();
        end
        set_in(0, '0, 1, 32'hB, 1);
        #1;
        total++;
        if (data_in_1_ready !== 1'b1) begin bad++; $display("FAIL skew_rdy1: got %b want 1", data_in_1_ready); end
        total++;
        if (data_out_0_valid !== 1'b0) begin bad++; $display("FAIL skew_valid_b: got %b want 0", data_out_0_valid); end
        tick();
        set_in(0, '0, 0, '0, 1);
        #1;
        total++;
        if (data_out_0_valid !== 1'b1) begin bad++; $display("FAIL skew_out_valid: got %b want 1", data_out_0_valid); end
        total++;
        if (data_out_0 !== 64'h0000000B_00000001) begin bad++; $display("FAIL skew_out_data: got %h want %h", data_out_0, 64'h0000000B_00000001); end
        total++;
        if (data_in_0_ready !== 1'b0) begin bad++; $display("FAIL skew_rdy0_full: got %b want 0", data_in_0_ready); end
        tick();
        #1;
        total++;
        if (data_in_0_ready !== 1'b1) begin bad++; $display("FAIL skew_rdy0_back: got %b want 1", data_in_0_ready); end
        total++;
        if (data_out_0_valid !== 1'b0) begin bad++; $display("FAIL skew_valid_after: got %b want 0", data_out_0_valid); end
        // Reset with a stale beat still queued on side 0 must discard it.
        apply_reset();
        set_in(0, '0, 1, 32'hC, 1);
        tick();
        set_in(0, '0, 0, '0, 1);
        #1;
        total++;
        if (data_out_0_valid !== 1'b0) begin bad++; $display("FAIL reset_discard: got %b want 0", data_out_0_valid); end
    endtask

    task automatic test_backpressure();
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            set_in(1, W0'(32'h100 + i), 1, W1'(32'h200 + i), 0);
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            set_in(0, '0, 0, '0, 0);
            #1;
            total++;
            if (data_out_0_valid !== 1'b1) begin bad++; $display("FAIL bp_valid cyc%0d: got %b want 1", i, data_out_0_valid); end
            total++;
            if (data_out_0 !== 64'h00000200_00000100) begin bad++; $display("FAIL bp_data cyc%0d: got %h want %h", i, data_out_0, 64'h00000200_00000100); end
            total++;
            if ((data_in_0_ready | data_in_1_ready) !== 1'b0) begin bad++; $display("FAIL bp_ready cyc%0d: got %b%b want 00", i, data_in_0_ready, data_in_1_ready); end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            set_in(0, '0, 0, '0, 1);
            #1;
            total++;
            if (data_out_0_valid !== (i < 2)) begin bad++; $display("FAIL bp_rel_valid cyc%0d: got %b want %b", i, data_out_0_valid, (i < 2)); end
            if (i < 2) begin
                total++;
                if (data_out_0 !== {W1'(32'h200 + i), W0'(32'h100 + i)}) begin bad++; $display("FAIL bp_rel_data cyc%0d: got %h want %h", i, data_out_0, {W1'(32'h200 + i), W0'(32'h100 + i)}); end
            end
            tick();
        end
    endtask

    task automatic test_wrap_random();
        logic [W0-1:0] s0[$];
        logic [W1-1:0] s1[$];
        int  i0, i1, nout, cyc;
        bit  v0, v1, ordy, exp_v;
        apply_reset();
        for (int k = 0; k < 20; k++) begin
            s0.push_back($urandom);
            s1.push_back($urandom);
        end
        i0 = 0; i1 = 0; nout = 0; cyc = 0;
        while (nout < 20 && cyc < 500) begin
            v0   = (i0 < 20) && ($urandom_range(0, 3) != 0);
            v1   = (i1 < 20) && ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            set_in(v0, v0 ? s0[i0] : W0'($urandom), v1, v1 ? s1[i1] : W1'($urandom), ordy);
            #1;
            exp_v = (q0.size() != 0) && (q1.size() != 0);
            total++;
            if (data_in_0_ready !== (q0.size() < DEPTH)) begin bad++; $display("FAIL wrap_rdy0 cyc%0d: got %b want %b", cyc, data_in_0_ready, (q0.size() < DEPTH)); end
            total++;
            if (data_in_1_ready !== (q1.size() < DEPTH)) begin bad++; $display("FAIL wrap_rdy1 cyc%0d: got %b want %b", cyc, data_in_1_ready, (q1.size() < DEPTH)); end
            total++;
            if (data_out_0_valid !== exp_v) begin bad++; $display("FAIL wrap_valid cyc%0d: got %b want %b", cyc, data_out_0_valid, exp_v); end
            if (exp_v) begin
                total++;
                if (data_out_0 !== {s1[nout], s0[nout]}) begin bad++; $display("FAIL wrap_data beat%0d: got %h want %h", nout, data_out_0, {s1[nout], s0[nout]}); end
                if (ordy) nout++;
            end
            if (v0 && q0.size() < DEPTH) i0++;
            if (v1 && q1.size() < DEPTH) i1++;
            tick();
            cyc++;
        end
        total++;
        if (nout != 20) begin bad++; $display("FAIL wrap_count: got %0d beats want 20 (cycle budget)", nout); end
        set_in(0, '0, 0, '0, 1);
        #1;
        total++;
        if (data_out_0_valid !== 1'b0) begin bad++; $display("FAIL wrap_no_dup: got valid %b want 0", data_out_0_valid); end
    endtask

`ifdef JOIN2_BUFFERED_STALL_CNT_EN
    task automatic test_stall_count();
        apply_reset();
        #1;
        total++;
        if (stall_count !== '0) begin bad++; $display("FAIL stall_reset: got %0d want 0", stall_count); end
        set_in(1, 32'h55, 0, '0, 0);
        tick();
        set_in(0, '0, 0, '0, 0);
        repeat (4) tick();
        #1;
        total++;
        if (stall_count !== SW'(4)) begin bad++; $display("FAIL stall_four: got %0d want 4", stall_count); end
        repeat (65541) @(posedge clk);
        @(negedge clk);
        total++;
        if (stall_count !== 16'hFFFF) begin bad++; $display("FAIL stall_saturate: got %h want ffff", stall_count); end
    endtask
`endif

    initial begin
        set_in(0, '0, 0, '0, 0);
        rst = 1'b1;
        test_reset();
        test_balanced();
        test_skew();
        test_backpressure();
        test_wrap_random();
`ifdef JOIN2_BUFFERED_STALL_CNT_EN
        test_stall_count();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
